// File: rtl/pcs_pkg.sv
// Shared PCS definitions for the 64b/66b encode/decode paths.
// Contents:
//   SYNC_DATA / SYNC_CTRL - legal 2-bit sync headers
//   TAP_A / TAP_B         - tap positions of the x^58 + x^39 + 1 scrambler
//   lock_state_t          - receive block-lock FSM states
//   sync_hdr_valid()      - true for a legal sync header
package pcs_pkg;

    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    localparam int unsigned TAP_A = 39;
    localparam int unsigned TAP_B = 58;

    typedef enum logic [1:0] {
        HUNT,
        SLIP,
        LOCKED
    } lock_state_t;

    function automatic logic sync_hdr_valid(input logic [1:0] hdr);
        return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
    endfunction

endpackage

// File: rtl/descrambler_64bit.sv
// Parallel 64-bit self-synchronous descrambler for x^58 + x^39 + 1.
// Ports:
//   CLK, RST_N - clock and asynchronous active-low reset
//   en         - advance the history register with this word
//   c[63:0]    - scrambled word, bit 0 earliest in time
//   d[63:0]    - descrambled word (combinational from c and history)
module descrambler_64bit
    import pcs_pkg::*;
(
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        en,
    input  logic [63:0] c,
    output logic [63:0] d
);

    // hist[k] holds c[64-TAP_B+k] of the previous enabled word.
    logic [TAP_B-1:0]    hist;
    // Bit stream in time order: ext[TAP_B + i] is c[i], lower bits are history.
    logic [TAP_B+63:0]   ext;

    assign ext = {c, hist};

    always_comb begin
        d = '0;
        for (int i = 0; i < 64; i++) begin
            d[i] = ext[i + TAP_B] ^ ext[i + TAP_B - TAP_A] ^ ext[i];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hist <= '1;
        end else if (en) begin
            // History tracks the received bits, not the descrambled ones.
            hist <= c[63:64-TAP_B];
        end
    end

endmodule

// File: rtl/pcs_rx_block_sync.sv
// 64b/66b receive block synchroniser and descrambler.
// Hunts for sync-header lock, requests gearbox slips until lock is found,
// monitors header quality while locked, and presents descrambled payloads.
// Ports:
//   CLK, RST_N  - clock and asynchronous active-low reset
//   rx_block    - [1:0] sync header, [65:2] scrambled payload (bit 2 earliest)
//   rx_valid    - rx_block valid this cycle
//   rx_slip     - one-cycle request to shift gearbox alignment by one bit
//   block_lock  - header lock achieved
//   data_out    - descrambled payload, bit 0 earliest
//   header_out  - sync header of the block on data_out
//   data_valid  - data_out/header_out valid (block arrived while locked)
//   hdr_err     - block on data_out had an invalid header
module pcs_rx_block_sync
    import pcs_pkg::*;
#(
    parameter int unsigned LOCK_CNT  = 64,
    parameter int unsigned BAD_LIMIT = 16,
    parameter int unsigned SLIP_WAIT = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [65:0] rx_block,
    input  logic        rx_valid,
    output logic        rx_slip,
    output logic        block_lock,
    output logic [63:0] data_out,
    output logic [1:0]  header_out,
    output logic        data_valid,
    output logic        hdr_err
);

    localparam int unsigned SH_W   = $clog2(LOCK_CNT + 1);
    localparam int unsigned BAD_W  = $clog2(BAD_LIMIT + 1);
    localparam int unsigned WAIT_W = $clog2(SLIP_WAIT + 1);

    lock_state_t       state;
    logic [SH_W-1:0]   sh_cnt;
    logic [BAD_W-1:0]  bad_cnt;
    logic [WAIT_W-1:0] wait_cnt;

    logic              hdr_ok;
    logic [SH_W-1:0]   sh_inc;
    logic [BAD_W-1:0]  bad_inc;
    logic [WAIT_W-1:0] wait_inc;
    logic [63:0]       descr;

    assign hdr_ok   = sync_hdr_valid(rx_block[1:0]);
    assign sh_inc   = sh_cnt + SH_W'(1);
    assign bad_inc  = bad_cnt + BAD_W'(!hdr_ok);
    assign wait_inc = wait_cnt + WAIT_W'(1);

    descrambler_64bit u_descrambler (
        .CLK   (CLK),
        .RST_N (RST_N),
        .en    (rx_valid),
        .c     (rx_block[65:2]),
        .d     (descr)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= HUNT;
            sh_cnt     <= '0;
            bad_cnt    <= '0;
            wait_cnt   <= '0;
            rx_slip    <= 1'b0;
            block_lock <= 1'b0;
            data_out   <= '0;
            header_out <= '0;
            data_valid <= 1'b0;
            hdr_err    <= 1'b0;
        end else begin
            rx_slip    <= 1'b0;
            data_valid <= 1'b0;
            hdr_err    <= 1'b0;
            if (rx_valid) begin
                data_out   <= descr;
                header_out <= rx_block[1:0];
                // block_lock here is the pre-edge value, so the block that
                // loses lock is still flagged valid.
                data_valid <= block_lock;
                hdr_err    <= !hdr_ok && block_lock;

                unique case (state)
                    HUNT: begin
                        if (hdr_ok) begin
                            if (sh_inc == SH_W'(LOCK_CNT)) begin
                                state      <= LOCKED;
                                block_lock <= 1'b1;
                                sh_cnt     <= '0;
                                bad_cnt    <= '0;
                            end else begin
                                sh_cnt <= sh_inc;
                            end
                        end else begin
                            rx_slip  <= 1'b1;
                            sh_cnt   <= '0;
                            bad_cnt  <= '0;
                            wait_cnt <= '0;
                            state    <= SLIP;
                        end
                    end
                    SLIP: begin
                        if (wait_inc == WAIT_W'(SLIP_WAIT)) begin
                            wait_cnt <= '0;
                            state    <= HUNT;
                        end else begin
                            wait_cnt <= wait_inc;
                        end
                    end
                    LOCKED: begin
                        // Loss of lock wins over end-of-window.
                        if (bad_inc == BAD_W'(BAD_LIMIT)) begin
                            block_lock <= 1'b0;
                            rx_slip    <= 1'b1;
                            sh_cnt     <= '0;
                            bad_cnt    <= '0;
                            wait_cnt   <= '0;
                            state      <= SLIP;
                        end else if (sh_inc == SH_W'(LOCK_CNT)) begin
                            sh_cnt  <= '0;
                            bad_cnt <= '0;
                        end else begin
                            sh_cnt  <= sh_inc;
                            bad_cnt <= bad_inc;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pcs_rx_block_sync.sv
// Self-checking bench for pcs_rx_block_sync: table-driven directed vectors,
// hand-written lock/slip sequences and a randomly gapped scrambled loopback,
// all checked against a behavioural scoreboard model.
module tb_pcs_rx_block_sync;

    logic        CLK;
    logic        RST_N;
    logic [65:0] rx_block;
    logic        rx_valid;
    logic        rx_slip;
    logic        block_lock;
    logic [63:0] data_out;
    logic [1:0]  header_out;
    logic        data_valid;
    logic        hdr_err;

    pcs_rx_block_sync #(
        .LOCK_CNT  (64),
        .BAD_LIMIT (16),
        .SLIP_WAIT (4)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .rx_block   (rx_block),
        .rx_valid   (rx_valid),
        .rx_slip    (rx_slip),
        .block_lock (block_lock),
        .data_out   (data_out),
        .header_out (header_out),
        .data_valid (data_valid),
        .hdr_err    (hdr_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int n_slip   = 0;
    int n_herr   = 0;

    typedef struct {
        logic        slip;
        logic        lock;
        logic        dv;
        logic        herr;
        logic [63:0] data;
        logic [1:0]  hdr;
    } exp_t;

    exp_t sb_q[$];

    // Behavioural model state
    int          m_st;  // 0 hunt, 1 slip, 2 locked
    int          m_sh;
    int          m_bad;
    int          m_wait;
    logic        m_lock;
    logic [63:0] m_data;
    logic [1:0]  m_hdr;
    logic [57:0] m_sr;  // m_sr[k] = received bit k+1 positions earlier

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_sh = 0; m_bad = 0; m_wait = 0;
        m_lock = 1'b0; m_data = '0; m_hdr = '0; m_sr = '1;
        sb_q.delete();
    endtask

    task automatic model_cycle(input logic v, input logic [65:0] blk, output exp_t e);
        logic ok;
        logic [63:0] dd;
        logic cb;
        e.slip = 1'b0; e.dv = 1'b0; e.herr = 1'b0;
        if (v) begin
            // Serial descrambler: one bit at a time in arrival order.
            dd = '0;
            for (int i = 0; i < 64; i++) begin
                cb = blk[2+i];
                dd[i] = cb ^ m_sr[38] ^ m_sr[57];
                m_sr = {m_sr[56:0], cb};
            end
            m_data = dd;
            m_hdr  = blk[1:0];
            ok = (blk[1:0] == 2'b01) || (blk[1:0] == 2'b10);
            e.dv   = m_lock;
            e.herr = m_lock && !ok;
            case (m_st)
                0: begin
                    if (ok) begin
                        m_sh++;
                        if (m_sh == 64) begin m_st = 2; m_lock = 1'b1; m_sh = 0; m_bad = 0; end
                    end else begin
                        e.slip = 1'b1; m_sh = 0; m_bad = 0; m_wait = 0; m_st = 1;
                    end
                end
                1: begin
                    m_wait++;
                    if (m_wait == 4) begin m_wait = 0; m_st = 0; end
                end
                default: begin
                    m_sh++;
                    if (!ok) m_bad++;
                    if (m_bad == 16) begin
                        m_lock = 1'b0; e.slip = 1'b1;
                        m_sh = 0; m_bad = 0; m_wait = 0; m_st = 1;
                    end else if (m_sh == 64) begin
                        m_sh = 0; m_bad = 0;
                    end
                end
            endcase
        end
        e.lock = m_lock;
        e.data = m_data;
        e.hdr  = m_hdr;
    endtask

    // Drive one cycle at the negedge, check after the following posedge.
    task automatic step(input logic v, input logic [65:0] blk);
        exp_t e;
        @(negedge CLK);
        rx_valid = v;
        rx_block = blk;
        model_cycle(v, blk, e);
        sb_q.push_back(e);
        @(posedge CLK);
        #1;
        e = sb_q.pop_front();
        chk("rx_slip", rx_slip, e.slip);
        chk("block_lock", block_lock, e.lock);
        chk("data_valid", data_valid, e.dv);
        chk("hdr_err", hdr_err, e.herr);
        chk("data_out", data_out, e.data);
        chk("header_out", header_out, e.hdr);
        n_slip += int'(rx_slip);
        n_herr += int'(hdr_err);
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic chk_all_zero(input string name);
        chk({name, "_slip"}, rx_slip, 0);
        chk({name, "_lock"}, block_lock, 0);
        chk({name, "_dout"}, data_out, 0);
        chk({name, "_hdr"}, header_out, 0);
        chk({name, "_dv"}, data_valid, 0);
        chk({name, "_herr"}, hdr_err, 0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST_N = 1'b0;
        #1;
        chk_all_zero("rst_async");
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            rx_valid = i[0];
            rx_block = {rnd64(), 2'(i)};
            @(posedge CLK);
            #1;
            chk_all_zero("rst_hold");
        end
        @(negedge CLK);
        RST_N    = 1'b1;
        rx_valid = 1'b0;
        rx_block = '0;
        model_reset();
        step(1'b0, '0);
        chk("post_rst_lock", block_lock, 0);
        chk("post_rst_slip", rx_slip, 0);
    endtask

    task automatic good_blocks(input int n);
        for (int i = 0; i < n; i++) step(1'b1, {rnd64(), 2'b01});
    endtask

    typedef struct {
        logic        v;
        logic [1:0]  hdr;
        logic [63:0] pay;
        logic        slip;
        logic        lock;
        logic        dv;
        logic        herr;
        logic [63:0] dout;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, h0, k;
        logic [63:0] seed, orig, scr;
        logic [57:0] t;
        logic b;

        RST_N    = 1'b0;
        rx_valid = 1'b0;
        rx_block = '0;
        model_reset();

        tbl[0] = '{1'b1, 2'b01, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h03FF_FF80_0000_0000};
        tbl[1] = '{1'b1, 2'b10, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0};
        tbl[2] = '{1'b0, 2'b01, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0};
        tbl[3] = '{1'b1, 2'b11, 64'h0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0};
        tbl[4] = '{1'b1, 2'b00, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0};
        tbl[5] = '{1'b0, 2'b00, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0};

        // Directed table: descrambler reset value, idle hold, hunt slip.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(tbl[i].v, {tbl[i].pay, tbl[i].hdr});
            chk($sformatf("tbl%0d_slip", i), rx_slip, tbl[i].slip);
            chk($sformatf("tbl%0d_lock", i), block_lock, tbl[i].lock);
            chk($sformatf("tbl%0d_dv", i), data_valid, tbl[i].dv);
            chk($sformatf("tbl%0d_herr", i), hdr_err, tbl[i].herr);
            chk($sformatf("tbl%0d_dout", i), data_out, tbl[i].dout);
        end

        // Lock acquisition from reset.
        do_reset();
        s0 = n_slip;
        good_blocks(63);
        chk("lock_63", block_lock, 0);
        good_blocks(1);
        chk("lock_64", block_lock, 1);
        chk("lock_64_dv", data_valid, 0);
        good_blocks(1);
        chk("lock_65_dv", data_valid, 1);
        chk("lock_no_slip", n_slip - s0, 0);

        // Hunt slip on block 10, four ignored blocks, then relock.
        do_reset();
        s0 = n_slip;
        good_blocks(9);
        step(1'b1, {rnd64(), 2'b00});
        chk("hunt_slip_pulse", rx_slip, 1);
        for (int i = 0; i < 4; i++) step(1'b1, {rnd64(), 2'b11});
        chk("hunt_slip_count", n_slip - s0, 1);
        good_blocks(63);
        chk("relock_63", block_lock, 0);
        good_blocks(1);
        chk("relock_64", block_lock, 1);

        // Window 1: 15 bad headers keep lock.
        s0 = n_slip;
        h0 = n_herr;
        for (int i = 0; i < 64; i++) step(1'b1, {rnd64(), (i < 15) ? 2'(i[0] ? 2'b11 : 2'b00) : 2'b10});
        chk("bad15_lock", block_lock, 1);
        chk("bad15_herr", n_herr - h0, 15);
        chk("bad15_slip", n_slip - s0, 0);

        // Window 2: 16th bad header at block 61 of the window.
        for (int i = 0; i <= 60; i++) step(1'b1, {rnd64(), (i % 4 == 0) ? 2'b00 : 2'b01});
        chk("bad16_lock", block_lock, 0);
        chk("bad16_slip", rx_slip, 1);
        chk("bad16_dv", data_valid, 1);
        chk("bad16_slip_count", n_slip - s0, 1);
        good_blocks(4 + 64);
        chk("relock_after_loss", block_lock, 1);

        // Window 3: 16th bad header is the last block of the window.
        s0 = n_slip;
        for (int i = 0; i < 64; i++) step(1'b1, {rnd64(), (i >= 48) ? 2'b11 : 2'b01});
        chk("edge_lock", block_lock, 0);
        chk("edge_slip", rx_slip, 1);
        chk("edge_slip_count", n_slip - s0, 1);

        // Scrambled loopback with random idle gaps.
        do_reset();
        seed = rnd64();
        t = seed[57:0];
        for (int n = 0; n < 1000; n++) begin
            if ($urandom_range(0, 3) == 0) step(1'b0, {rnd64(), 2'b11});
            orig = rnd64();
            scr  = '0;
            for (int i = 0; i < 64; i++) begin
                b = orig[i] ^ t[38] ^ t[57];
                scr[i] = b;
                t = {t[56:0], b};
            end
            step(1'b1, {scr, 2'b01});
            if (n >= 1) chk($sformatf("loop%0d", n), data_out, orig);
        end
        chk("loop_lock", block_lock, 1);

        // Reset in mid-operation returns to hunt.
        do_reset();
        k = n_checks;
        chk("midrst_lock", block_lock, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pcs_rx_block_sync.md
# pcs_rx_block_sync

Receive-side counterpart of the 64b/66b transmit encoder/scrambler path in the PCS. Accepts one 66-bit block per cycle from the RX gearbox and acquires block lock on the 2-bit sync header, driving a slip request back to the gearbox until lock is found. Payloads are descrambled with the self-synchronous x^58+x^39+1 polynomial, and 64-bit data plus header are presented to the downstream decoder.

## Interface
- LOCK_CNT, 64: consecutive valid headers required for lock; also the length of the monitoring window while locked
- BAD_LIMIT, 16: invalid headers within one window that cause loss of lock
- SLIP_WAIT, 4: valid blocks ignored after a slip while the gearbox realigns
- CLK  input  1  sole clock; all logic on posedge
- RST_N  input  1  asynchronous, active-low reset
- rx_block  input  66  [1:0] sync header (2'b01 data, 2'b10 control); [65:2] scrambled payload, bit 2 earliest in time
- rx_valid  input  1  rx_block is valid this cycle
- rx_slip  output  1  one-cycle pulse: gearbox shifts alignment by one bit
- block_lock  output  1  header lock achieved
- data_out  output  64  descrambled payload, bit 0 earliest
- header_out  output  2  sync header of the block on data_out
- data_valid  output  1  data_out/header_out valid
- hdr_err  output  1  one-cycle pulse: the block on data_out had an invalid header (00 or 11)

## Operation
- Reset: all outputs 0. FSM is in HUNT, counters are 0, and the descrambler state is all ones.
- Counters: sh_cnt has width $clog2(LOCK_CNT+1). bad_cnt has width $clog2(BAD_LIMIT+1). Neither wraps.
- Only cycles with rx_valid=1 advance the FSM, the counters or the descrambler. Idle cycles hold all state, and pulses deassert.
- HUNT (block_lock=0):
  - Valid header: sh_cnt++. When sh_cnt reaches LOCK_CNT, go to LOCKED, set block_lock=1 and clear the counters.
  - Invalid header: pulse rx_slip, clear the counters, go to SLIP.
- SLIP: count SLIP_WAIT valid blocks, discarding their headers, then go to HUNT. No further rx_slip is issued in this state.
- LOCKED (block_lock=1):
  - Every valid block: sh_cnt++. An invalid header also does bad_cnt++.
  - If bad_cnt reaches BAD_LIMIT: block_lock=0, pulse rx_slip, clear the counters, go to SLIP.
  - Otherwise, when sh_cnt reaches LOCK_CNT, clear both counters and stay LOCKED.
  - If the BAD_LIMIT-th bad header lands on the last block of a window, loss of lock has priority.
- Descrambler:
  - Runs on every valid block regardless of lock state.
  - For payload bit i (c = scrambled input): d[i] = c[i] ^ c[i-39] ^ c[i-58]. Negative indices read the 58-bit history register, which holds c[63:6] of the previous valid block.
  - The history register is updated with the received (scrambled) bits, so the descrambler self-synchronises after 58 bits.
- Output stage, registered on each valid block:
  - data_out=d and header_out=rx_block[1:0].
  - data_valid = block_lock as it was before this edge's update.
  - hdr_err = invalid header AND data_valid.
- Reset asserted mid-operation returns everything to reset values immediately. Lock must be reacquired from HUNT.

## Timing
- Latency: one cycle from rx_valid to data_valid/data_out.
- rx_slip asserts on the edge that consumes the offending block and lasts exactly one cycle.
- block_lock rises on the edge consuming the LOCK_CNT-th consecutive valid header. The first data_valid=1 is the following valid block.
- block_lock falls on the edge consuming the BAD_LIMIT-th bad header. data_valid=1 still applies to that block.
- data_valid and hdr_err are 0 in every cycle after rx_valid=0.
- Back-to-back blocks: one block per cycle, no stalls.

## Structure
- Shared package pcs_pkg:
  - SYNC_DATA=2'b01 and SYNC_CTRL=2'b10
  - scrambler taps TAP_A=39 and TAP_B=58
  - the lock FSM enum {HUNT, SLIP, LOCKED}
  - this package is reused by the TX encoder/scrambler
- Sub-module descrambler_64bit:
  - ports CLK, RST_N, en, c[63:0], d[63:0]
  - holds the 58-bit history register, reset to all ones
  - combinational d, history updated when en=1
- The top level holds the FSM, the counters and the output registers.

## Test plan
- Reset: hold RST_N=0 with rx_valid toggling → all outputs 0. Release → block_lock=0 and no rx_slip.
- Lock: 64 consecutive valid blocks with header 2'b01 → block_lock=1 after the 64th edge, no rx_slip, data_valid=1 from block 65 with one-cycle latency.
- Hunt slip: header 2'b00 on block 10 → single rx_slip pulse. The next 4 valid blocks are ignored even if bad. Lock is reached 64 valid blocks after that.
- Bad limit: locked, inject 15 bad headers in one 64-block window → block_lock stays 1 and hdr_err pulses 15 times. Inject 16 → block_lock=0 and one rx_slip pulse. Repeat with the 16th bad header as the 64th block of the window → lock is lost.
- Descrambler: after reset, payload 64'h0 → data_out=64'h03FF_FF80_0000_0000. A second all-zero payload → 64'h0.
- Loopback: 1000 random payloads scrambled by the bench reference model (x^58+x^39+1, any seed), rx_valid randomly gapped → data_out matches the original payloads from the second block onward.
